// File: rtl/cfi_log_queue_if.sv
// CFI log queue record type and port bundle.
// The package holds the record format shared by commit, queue and checker.
// The interface groups the commit-side push port, the checker-side pop port
// and the status outputs. Modport slave is the queue; master is its environment.
package cfi_log_queue_pkg;
  typedef struct packed {
    logic [31:0] addr_pc;  // committed instruction PC
    logic [31:0] target;   // resolved control-flow target
  } cfi_log_t;
endpackage

interface cfi_log_queue_if #(
  parameter int NR_COMMIT_PORTS = 2
);
  import cfi_log_queue_pkg::*;

  cfi_log_t [NR_COMMIT_PORTS-1:0] log_i;
  logic     [NR_COMMIT_PORTS-1:0] cfi_i;
  logic                           flush_i;
  cfi_log_t                       log_o;
  logic                           valid_o;
  logic                           ready_i;
  logic                           stall_o;
  logic                           ovf_o;
  logic     [15:0]                ovf_cnt_o;

  modport slave (
    input  log_i, cfi_i, flush_i, ready_i,
    output log_o, valid_o, stall_o, ovf_o, ovf_cnt_o
  );

  modport master (
    output log_i, cfi_i, flush_i, ready_i,
    input  log_o, valid_o, stall_o, ovf_o, ovf_cnt_o
  );
endinterface

// File: rtl/cfi_log_queue.sv
// CFI log queue: compacts up to NR_COMMIT_PORTS flagged commit records per
// cycle into a circular FIFO and hands them one per cycle to the checker.
// Free space is judged from registered occupancy only, so a same-cycle pop
// never makes room for that cycle's pushes; records that do not fit are
// dropped and accounted for.
// Optional feature: define CFI_LOG_QUEUE_OVF_CNT_EN to build the 16-bit
// saturating dropped-record counter; otherwise ovf_cnt_o is tied to 0.
module cfi_log_queue
  import cfi_log_queue_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int DEPTH           = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  cfi_log_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // extra wrap bit distinguishes full from empty
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] NR_P    = PW'(NR_COMMIT_PORTS);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_stall;
  logic          r_ovf;
  cfi_log_t      r_mem [DEPTH];

  logic [PW-1:0] w_count, w_free;
  logic [PW-1:0] w_nflag, w_npush, w_ndrop;
  logic [PW-1:0] w_count_nxt;
  logic          w_pop;
  logic [NR_COMMIT_PORTS-1:0]         w_we;
  logic [NR_COMMIT_PORTS-1:0][AW-1:0] w_idx;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_free  = DEPTH_P - w_count;
  assign w_pop   = (w_count != '0) && bus.ready_i;

  // Compaction: the k-th flagged port goes to wr_ptr+k if it fits in free space
  always_comb begin
    w_nflag = '0;
    w_we    = '0;
    w_idx   = '0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (bus.cfi_i[p]) begin
        if (w_nflag < w_free) begin
          w_we[p]  = !bus.flush_i;
          w_idx[p] = AW'(r_wr_ptr + w_nflag);
        end
        w_nflag = w_nflag + 1'b1;
      end
    end
    w_npush     = (w_nflag < w_free) ? w_nflag : w_free;
    w_ndrop     = w_nflag - w_npush;
    w_count_nxt = w_count + w_npush - PW'(w_pop);
  end

  // Record storage; not reset, contents are only meaningful below count
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NR_COMMIT_PORTS; p++)
      if (w_we[p]) r_mem[w_idx[p]] <= bus.log_i[p];
  end

  // Pointers and registered almost-full / sticky overflow status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_stall  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_stall  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_npush;
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_stall  <= (DEPTH_P - w_count_nxt) < NR_P;
      if (w_ndrop != '0) r_ovf <= 1'b1;
    end
  end

`ifdef CFI_LOG_QUEUE_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;
  logic [16:0] w_cnt_sum;
  assign w_cnt_sum = {1'b0, r_ovf_cnt} + 17'(w_ndrop);

  // Saturating count of dropped records
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) r_ovf_cnt <= '0;
    else if (w_cnt_sum[16])   r_ovf_cnt <= 16'hFFFF;
    else                      r_ovf_cnt <= w_cnt_sum[15:0];
  end
  assign bus.ovf_cnt_o = r_ovf_cnt;
`else
  assign bus.ovf_cnt_o = 16'h0;
`endif

  assign bus.valid_o = (w_count != '0);
  assign bus.log_o   = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.stall_o = r_stall;
  assign bus.ovf_o   = r_ovf;
endmodule

// File: tb/tb_cfi_log_queue.sv
// Directed table + hand sequences for cfi_log_queue (2 ports, depth 8).
module tb_cfi_log_queue;
  import cfi_log_queue_pkg::*;
  localparam int NR = 2;
  localparam int D  = 8;
`ifdef CFI_LOG_QUEUE_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cfi_log_queue_if #(.NR_COMMIT_PORTS(NR)) bus ();
  cfi_log_queue #(.NR_COMMIT_PORTS(NR), .DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  cfi;
    logic [31:0] pc0, pc1;
    logic        rdy, fl;
    logic        ev;
    logic [31:0] epc;
    logic        est, eovf;
    logic [15:0] ecnt;
  } vec_t;
  vec_t tv[$];

  function automatic cfi_log_t mk(input logic [31:0] pc);
    cfi_log_t r;
    r.addr_pc = pc;
    r.target  = ~pc;
    return r;
  endfunction

  function automatic vec_t v(input logic [1:0] cfi, input logic [31:0] pc0, pc1,
                             input logic rdy, fl, ev, input logic [31:0] epc,
                             input logic est, eovf, input logic [15:0] ecnt);
    vec_t r;
    r.cfi = cfi; r.pc0 = pc0; r.pc1 = pc1; r.rdy = rdy; r.fl = fl;
    r.ev = ev; r.epc = epc; r.est = est; r.eovf = eovf; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cfi, input logic [31:0] pc0, pc1,
                       input logic rdy, fl);
    bus.cfi_i    = cfi;
    bus.log_i[0] = mk(pc0);
    bus.log_i[1] = mk(pc1);
    bus.ready_i  = rdy;
    bus.flush_i  = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard state for the random phase
  cfi_log_t    q[$];
  logic        m_ovf;
  int          m_cnt;

  initial begin
    drive(2'b00, 0, 0, 1'b0, 1'b0);
    tick(); tick();
    check("reset valid", 64'(bus.valid_o), 64'd0);
    check("reset stall", 64'(bus.stall_o), 64'd0);
    check("reset ovf", 64'(bus.ovf_o), 64'd0);
    check("reset cnt", 64'(bus.ovf_cnt_o), 64'd0);
    rst = 1'b0;

    // single record
    tv.push_back(v(2'b10, 0, 32'h8000_0100, 1, 0, 1, 32'h8000_0100, 0, 0, 0));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // compaction and order
    tv.push_back(v(2'b11, 32'hA0, 32'hA1, 0, 0, 1, 32'hA0, 0, 0, 0));
    tv.push_back(v(2'b01, 32'hB0, 32'hEE, 0, 0, 1, 32'hA0, 0, 0, 0));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'hA1, 0, 0, 0));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'hB0, 0, 0, 0));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // fill and overflow
    tv.push_back(v(2'b11, 32'h10, 32'h11, 0, 0, 1, 32'h10, 0, 0, 0));
    tv.push_back(v(2'b11, 32'h12, 32'h13, 0, 0, 1, 32'h10, 0, 0, 0));
    tv.push_back(v(2'b11, 32'h14, 32'h15, 0, 0, 1, 32'h10, 0, 0, 0));
    tv.push_back(v(2'b11, 32'h16, 32'h17, 0, 0, 1, 32'h10, 1, 0, 0));
    tv.push_back(v(2'b11, 32'h18, 32'h19, 0, 0, 1, 32'h10, 1, 1, 2));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'h11, 1, 1, 2));
    // partial fit: free=1, pop does not help
    tv.push_back(v(2'b11, 32'hC0, 32'hC1, 1, 0, 1, 32'h12, 1, 1, 3));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'h13, 0, 1, 3));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'h14, 0, 1, 3));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'h15, 0, 1, 3));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'h16, 0, 1, 3));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'h17, 0, 1, 3));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 1, 32'hC0, 0, 1, 3));
    tv.push_back(v(2'b00, 0, 0, 1, 0, 0, 0, 0, 1, 3));
    // refill to stall, then flush with a push and pop pending
    tv.push_back(v(2'b11, 32'h20, 32'h21, 0, 0, 1, 32'h20, 0, 1, 3));
    tv.push_back(v(2'b11, 32'h22, 32'h23, 0, 0, 1, 32'h20, 0, 1, 3));
    tv.push_back(v(2'b11, 32'h24, 32'h25, 0, 0, 1, 32'h20, 0, 1, 3));
    tv.push_back(v(2'b11, 32'h26, 32'h27, 0, 0, 1, 32'h20, 1, 1, 3));
    tv.push_back(v(2'b11, 32'h30, 32'h31, 1, 1, 0, 0, 0, 0, 0));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tv[i]) begin
      drive(tv[i].cfi, tv[i].pc0, tv[i].pc1, tv[i].rdy, tv[i].fl);
      tick();
      check($sformatf("v%0d valid", i), 64'(bus.valid_o), 64'(tv[i].ev));
      if (tv[i].ev)
        check($sformatf("v%0d head", i), 64'(bus.log_o), 64'(mk(tv[i].epc)));
      check($sformatf("v%0d stall", i), 64'(bus.stall_o), 64'(tv[i].est));
      check($sformatf("v%0d ovf", i), 64'(bus.ovf_o), 64'(tv[i].eovf));
      check($sformatf("v%0d cnt", i), 64'(bus.ovf_cnt_o),
            CNT_EN ? 64'(tv[i].ecnt) : 64'd0);
    end

    // reset while a head is waiting
    drive(2'b11, 32'h40, 32'h41, 0, 0); tick();
    drive(2'b00, 0, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst mid valid", 64'(bus.valid_o), 64'd0);

    // random traffic against a queue model
    q.delete(); m_ovf = 1'b0; m_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      logic [1:0]  cfi;
      logic        rdy;
      logic [31:0] p0, p1;
      int          fr;
      cfi = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      p0  = $urandom; p1 = $urandom;
      drive(cfi, p0, p1, rdy, 1'b0);
      fr = D - q.size();
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (cfi[0]) begin
        if (fr > 0) begin q.push_back(mk(p0)); fr--; end
        else begin m_ovf = 1'b1; m_cnt++; end
      end
      if (cfi[1]) begin
        if (fr > 0) begin q.push_back(mk(p1)); fr--; end
        else begin m_ovf = 1'b1; m_cnt++; end
      end
      tick();
      check("rnd valid", 64'(bus.valid_o), 64'(q.size() != 0));
      if (q.size() != 0) check("rnd head", 64'(bus.log_o), 64'(q[0]));
      check("rnd stall", 64'(bus.stall_o), 64'((D - q.size()) < NR));
      check("rnd ovf", 64'(bus.ovf_o), 64'(m_ovf));
      check("rnd cnt", 64'(bus.ovf_cnt_o), CNT_EN ? 64'(m_cnt) : 64'd0);
    end

    // saturation: fill, then 35000 cycles of two drops each
    drive(2'b00, 0, 0, 0, 1'b1); tick();
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 32'h50 + c, 32'h60 + c, 0, 0); tick();
    end
    for (int c = 0; c < 35000; c++) begin
      drive(2'b11, 32'h70, 32'h71, 0, 0);
      @(posedge clk);
    end
    #1;
    drive(2'b00, 0, 0, 0, 0);
    check("sat ovf", 64'(bus.ovf_o), 64'd1);
    check("sat cnt", 64'(bus.ovf_cnt_o), CNT_EN ? 64'hFFFF : 64'd0);
    check("sat head", 64'(bus.log_o), 64'(mk(32'h50)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
